// File: rtl/multi_channel_capture_buffer_pkg.sv
// Shared types and helpers for the multi-channel capture buffer.
package multi_channel_capture_buffer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_HEADER  = 3'd3,
        ST_SEND    = 3'd4
    } state_t;

    localparam logic [31:0] HEADER_DEFAULT = 32'hFF807F00;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // A request of 0 or anything beyond the storage means "fill the whole RAM".
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
        return (len == 0 || len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/multi_channel_capture_buffer_ram.sv
// Simple dual-port sample store: one write port, one registered read port, no reset.
module capture_sdp_ram
    import multi_channel_capture_buffer_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 1024
) (
    input  logic                      i_Clock,
    input  logic                      i_we,
    input  logic [clog2(DEPTH)-1:0]   i_waddr,
    input  logic [W-1:0]              i_wdata,
    input  logic [clog2(DEPTH)-1:0]   i_raddr,
    output logic [W-1:0]              o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_Clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/multi_channel_capture_buffer.sv
// Trigger-armed sample capture into RAM, then streams signature + samples as bytes.
module multi_channel_capture_buffer
    import multi_channel_capture_buffer_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          SAMPLE_W   = 8,
    parameter int          DEPTH      = 1024,
    parameter logic [31:0] HEADER     = HEADER_DEFAULT,
    parameter bit          AUTO_REARM = 1'b0
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset_n,
    input  logic [NUM_CH*SAMPLE_W-1:0]   i_DataIn,
    input  logic                         i_DataInValid,
    input  logic                         i_Arm,
    input  logic [clog2(DEPTH):0]        i_CaptureLen,
    input  logic                         i_Trigger,
    input  logic                         i_Abort,
    output logic [7:0]                   o_OutData,
    output logic                         o_OutValid,
    input  logic                         i_OutReady,
    output logic                         o_Armed,
    output logic                         o_Busy,
    output logic [clog2(DEPTH):0]        o_SampleCount,
    output logic [2:0]                   o_State
);
    localparam int W  = NUM_CH * SAMPLE_W;
    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int NB = W / 8;
    localparam int BW = clog2(NB) + 1;

    state_t          r_state, w_next;
    logic            r_trig_d, w_edge;
    logic [AW:0]     r_len, r_cnt, r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr, w_raddr;
    logic [W-1:0]    r_word, w_rdata;
    logic [BW-1:0]   r_bidx;
    logic [2:0]      r_hdr_idx;
    logic [7:0]      r_out_data, w_hdr_byte;
    logic            r_out_valid;
    logic            w_adv, w_wr, w_done, w_hdr_last, w_load_word, w_send_done;

    always_comb begin
        w_edge      = i_Trigger & ~r_trig_d;
        w_adv       = ~r_out_valid | i_OutReady;
        w_wr        = i_DataInValid & ((r_state == ST_CAPTURE) | ((r_state == ST_ARMED) & w_edge));
        w_done      = w_wr & ((r_cnt + 1'b1) == r_len);
        w_hdr_last  = (r_state == ST_HEADER) & w_adv & (r_hdr_idx == 3'd4);
        // Word k is fetched from RAM at the edge that loads word k-1, so the next
        // word is already sitting on the read port when its first byte is due.
        w_load_word = w_hdr_last |
                      ((r_state == ST_SEND) & w_adv & (r_bidx == '0) & (r_rd_ptr != r_len));
        w_send_done = (r_state == ST_SEND) & r_out_valid & i_OutReady &
                      (r_bidx == '0) & (r_rd_ptr == r_len);
        w_raddr     = w_load_word ? r_rd_ptr[AW-1:0] + 1'b1 : r_rd_ptr[AW-1:0];
        w_hdr_byte  = 8'(HEADER >> (8 * (3 - r_hdr_idx[1:0])));
    end

    always_comb begin
        w_next = r_state;
        if (i_Abort) begin
            w_next = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:    if (i_Arm) w_next = ST_ARMED;
                ST_ARMED:   if (w_done) w_next = ST_HEADER;
                            else if (w_edge) w_next = ST_CAPTURE;
                ST_CAPTURE: if (w_done) w_next = ST_HEADER;
                ST_HEADER:  if (w_hdr_last) w_next = ST_SEND;
                ST_SEND:    if (w_send_done) w_next = AUTO_REARM ? ST_ARMED : ST_IDLE;
                default:    w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) r_trig_d <= 1'b1;
        else            r_trig_d <= i_Trigger;

        if (!i_Reset_n) begin
            r_len       <= LW'(DEPTH);
            r_cnt       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_word      <= '0;
            r_bidx      <= '0;
            r_hdr_idx   <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (i_Abort) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_bidx      <= '0;
            r_hdr_idx   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE && i_Arm) || (r_state == ST_ARMED && i_Arm && !w_edge))
                r_len <= LW'(clamp_len(32'(i_CaptureLen), DEPTH));
            if ((r_state == ST_IDLE && i_Arm) || (w_send_done && AUTO_REARM)) begin
                r_cnt    <= '0;
                r_wr_ptr <= '0;
            end
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_cnt    <= r_cnt + 1'b1;
            end
            // The first signature byte is presented in the same edge as the last write.
            if (w_done) begin
                r_out_data  <= HEADER[31:24];
                r_out_valid <= 1'b1;
                r_hdr_idx   <= 3'd1;
                r_rd_ptr    <= '0;
            end
            if (r_state == ST_HEADER && w_adv && r_hdr_idx != 3'd4) begin
                r_out_data <= w_hdr_byte;
                r_hdr_idx  <= r_hdr_idx + 3'd1;
            end
            if (r_state == ST_SEND && w_adv && r_bidx != '0) begin
                r_out_data <= r_word[W-1 -: 8];
                r_word     <= r_word << 8;
                r_bidx     <= r_bidx - 1'b1;
            end
            if (w_load_word) begin
                r_out_data  <= w_rdata[W-1 -: 8];
                r_word      <= w_rdata << 8;
                r_bidx      <= BW'(NB - 1);
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_out_valid <= 1'b1;
            end
            if (w_send_done) r_out_valid <= 1'b0;
        end
    end

    capture_sdp_ram #(.W(W), .DEPTH(DEPTH)) u_ram (
        .i_Clock (i_Clock),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_DataIn),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign o_OutData     = r_out_data;
    assign o_OutValid    = r_out_valid;
    assign o_Armed       = (r_state == ST_ARMED);
    assign o_Busy        = (r_state == ST_CAPTURE) | (r_state == ST_HEADER) | (r_state == ST_SEND);
    assign o_SampleCount = r_cnt;
    assign o_State       = r_state;

endmodule

// File: tb/tb_multi_channel_capture_buffer.sv
// Randomized bench: captured words are modelled as a queue, packets as signature + word bytes.
module tb_multi_channel_capture_buffer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, dv, arm, trig, abort, rdy, arm_b, trig_b, abort_b, rdy_b;
    logic [31:0] din;
    logic [4:0]  len;
    logic [7:0]  od, od_b;
    logic        ov, ov_b, armed, armed_b, busy, busy_b;
    logic [4:0]  sc, sc_b;
    logic [2:0]  st, st_b;

    int checks = 0, errors = 0, cyc = 0;
    logic [31:0] exp_w[$];
    logic [7:0]  got_a[$], got_b[$];
    int          cyc_a[$];

    multi_channel_capture_buffer #(.NUM_CH(4), .SAMPLE_W(8), .DEPTH(16), .AUTO_REARM(1'b0)) u_dut (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_DataIn(din), .i_DataInValid(dv), .i_Arm(arm),
        .i_CaptureLen(len), .i_Trigger(trig), .i_Abort(abort), .o_OutData(od), .o_OutValid(ov),
        .i_OutReady(rdy), .o_Armed(armed), .o_Busy(busy), .o_SampleCount(sc), .o_State(st));

    multi_channel_capture_buffer #(.NUM_CH(4), .SAMPLE_W(8), .DEPTH(16), .AUTO_REARM(1'b1)) u_dut_b (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_DataIn(din), .i_DataInValid(dv), .i_Arm(arm_b),
        .i_CaptureLen(len), .i_Trigger(trig_b), .i_Abort(abort_b), .o_OutData(od_b), .o_OutValid(ov_b),
        .i_OutReady(rdy_b), .o_Armed(armed_b), .o_Busy(busy_b), .o_SampleCount(sc_b), .o_State(st_b));

    always @(posedge clk) cyc <= cyc + 1;

    // Byte collection plus the hold-while-stalled rule, both judged between edges.
    logic       stall_p = 1'b0, abort_p = 1'b0, rst_p = 1'b0;
    logic [7:0] stall_d = 8'h00;
    always @(negedge clk) begin
        if (stall_p && rst_p && !abort_p) begin
            checks++;
            if (ov !== 1'b1 || od !== stall_d) begin
                errors++;
                $display("FAIL hold: valid=%b data=%h required valid=1 data=%h", ov, od, stall_d);
            end
        end
        if (ov && rdy) begin got_a.push_back(od); cyc_a.push_back(cyc); end
        if (ov_b && rdy_b) got_b.push_back(od_b);
        stall_p = ov && !rdy;
        stall_d = od;
        abort_p = abort;
        rst_p   = rst_n;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_capture(input int sel, input bit do_arm, input int len_req, input int vpct, input bit incr);
        int n, eff;
        logic [31:0] d;
        logic [2:0]  s;
        logic        v;
        logic [7:0]  o;
        n   = 0;
        eff = (len_req == 0 || len_req > 16) ? 16 : len_req;
        exp_w.delete(); got_a.delete(); cyc_a.delete(); got_b.delete();
        len = 5'(len_req);
        if (sel == 0) begin trig = 1'b0; arm = do_arm; end
        else begin trig_b = 1'b0; arm_b = do_arm; end
        tick;
        arm = 1'b0; arm_b = 1'b0;
        if (sel == 0) trig = 1'b1; else trig_b = 1'b1;
        d = incr ? 32'h00010203 : $urandom;
        for (int c = 0; c < 500 && n < eff; c++) begin
            din = d;
            dv  = ($urandom_range(99) < vpct);
            tick;
            if (dv) begin exp_w.push_back(d); n++; end
            d = incr ? d + 32'h04040404 : $urandom;
        end
        dv = 1'b0;
        if (sel == 0) begin trig = 1'b0; s = st; v = ov; o = od; end
        else begin trig_b = 1'b0; s = st_b; v = ov_b; o = od_b; end
        checks++;
        if (n != eff || s !== 3'd3 || v !== 1'b1 || o !== 8'hFF) begin
            errors++;
            $display("FAIL capture_end: words=%0d state=%0d valid=%b data=%h required words=%0d state=3 valid=1 data=ff",
                     n, s, v, o, eff);
        end
    endtask

    task automatic get_packet(input int sel, input int rmode, input int trig_at, input logic [2:0] end_state);
        logic [7:0]  exp_b[$], g[$];
        logic [31:0] w;
        logic        r, bubble;
        int          t;
        exp_b = {8'hFF, 8'h80, 8'h7F, 8'h00};
        foreach (exp_w[i]) begin
            w = exp_w[i];
            for (int k = 3; k >= 0; k--) exp_b.push_back(w[8*k +: 8]);
        end
        t = 0;
        while (((sel == 0) ? got_a.size() : got_b.size()) < exp_b.size() && t < 3000) begin
            r = (rmode == 0) ? 1'b1 : 1'($urandom_range(1));
            if (sel == 0) rdy = r; else rdy_b = r;
            if (sel == 1 && trig_at >= 0 && got_b.size() >= trig_at) trig_b = 1'b1;
            tick;
            t++;
        end
        if (sel == 0) g = got_a; else g = got_b;
        checks++;
        if (g.size() != exp_b.size()) begin
            errors++;
            $display("FAIL pkt_len: got %0d bytes required %0d", g.size(), exp_b.size());
        end
        foreach (exp_b[i]) if (i < g.size()) begin
            checks++;
            if (g[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL pkt_byte[%0d]: got %h required %h", i, g[i], exp_b[i]);
            end
        end
        if (sel == 0 && rmode == 0) begin
            bubble = 1'b0;
            foreach (cyc_a[i]) if (cyc_a[i] != cyc_a[0] + i) bubble = 1'b1;
            checks++;
            if (bubble) begin errors++; $display("FAIL no_bubble: gap seen, required one byte per cycle"); end
        end
        checks++;
        if (sel == 0) begin
            if (st !== end_state || ov !== 1'b0 || sc !== 5'(exp_w.size())) begin
                errors++;
                $display("FAIL pkt_end: state=%0d valid=%b count=%0d required state=%0d valid=0 count=%0d",
                         st, ov, sc, end_state, exp_w.size());
            end
        end else if (st_b !== end_state || ov_b !== 1'b0 || armed_b !== 1'b1 || sc_b !== 5'd0) begin
            errors++;
            $display("FAIL rearm_end: state=%0d valid=%b armed=%b count=%0d required state=%0d valid=0 armed=1 count=0",
                     st_b, ov_b, armed_b, sc_b, end_state);
        end
        rdy = 1'b0; rdy_b = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; trig = 1'b1; len = 5'd3;
        repeat (3) tick;
        checks++;
        if (st !== 3'd0 || ov !== 1'b0 || od !== 8'h00 || sc !== 5'd0 || armed !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: state=%0d valid=%b data=%h count=%0d armed=%b busy=%b required all 0",
                     st, ov, od, sc, armed, busy);
        end
        rst_n = 1'b1; arm = 1'b1; tick; arm = 1'b0;
        repeat (4) tick;
        checks++;
        if (st !== 3'd1 || armed !== 1'b1) begin
            errors++; $display("FAIL held_trigger: state=%0d armed=%b required state=1 armed=1", st, armed);
        end
        trig = 1'b0; tick; trig = 1'b1; tick;
        checks++;
        if (st !== 3'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL trigger_edge: state=%0d busy=%b required state=2 busy=1", st, busy);
        end
        trig = 1'b0; abort = 1'b1; tick; abort = 1'b0;
        checks++;
        if (st !== 3'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_capture: state=%0d busy=%b required state=0 busy=0", st, busy);
        end
    endtask

    task automatic test_basic;
        do_capture(0, 1'b1, 3, 100, 1'b1);
        get_packet(0, 0, -1, 3'd0);
    endtask

    task automatic test_backpressure;
        do_capture(0, 1'b1, 3, 100, 1'b1);
        get_packet(0, 1, -1, 3'd0);
    endtask

    task automatic test_len_wrap;
        do_capture(0, 1'b1, 0, 80, 1'b0);
        get_packet(0, 0, -1, 3'd0);
        do_capture(0, 1'b1, 1, 100, 1'b0);
        get_packet(0, 0, -1, 3'd0);
    endtask

    task automatic test_random;
        repeat (4) begin
            do_capture(0, 1'b1, int'($urandom_range(0, 31)), 60, 1'b0);
            get_packet(0, 1, -1, 3'd0);
        end
    endtask

    task automatic test_abort;
        int t;
        arm = 1'b1; abort = 1'b1; tick; arm = 1'b0; abort = 1'b0;
        checks++;
        if (st !== 3'd0) begin errors++; $display("FAIL arm_vs_abort: state=%0d required 0", st); end
        rdy = 1'b1;
        do_capture(0, 1'b1, 4, 100, 1'b0);
        t = 0;
        while (got_a.size() < 7 && t < 200) begin tick; t++; end
        abort = 1'b1; tick; abort = 1'b0;
        checks++;
        if (got_a.size() < 7 || st !== 3'd0 || ov !== 1'b0 || sc !== 5'd4) begin
            errors++;
            $display("FAIL abort_send: bytes=%0d state=%0d valid=%b count=%0d required bytes>=7 state=0 valid=0 count=4",
                     got_a.size(), st, ov, sc);
        end
        rdy = 1'b0;
        do_capture(0, 1'b1, 2, 70, 1'b0);
        get_packet(0, 1, -1, 3'd0);
    endtask

    task automatic test_auto_rearm;
        do_capture(1, 1'b1, 2, 100, 1'b0);
        get_packet(1, 0, 6, 3'd1);
        do_capture(1, 1'b0, 2, 100, 1'b0);
        get_packet(1, 0, -1, 3'd1);
    endtask

    initial begin
        rst_n = 1'b0; dv = 1'b0; din = '0; len = '0;
        arm = 1'b0; trig = 1'b0; abort = 1'b0; rdy = 1'b0;
        arm_b = 1'b0; trig_b = 1'b0; abort_b = 1'b0; rdy_b = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_len_wrap();
        test_random();
        test_abort();
        test_auto_rearm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
